// File: rtl/lsq_unit.sv
`default_nettype none
// ============================================================================
// Module   : lsq_unit
// Brief    : Load/store queue and memory-access stage. Keeps in-flight memory
//            ops in program order, forwards store data to younger loads,
//            issues one outstanding cache read and writes stores at commit.
// Revision : 1.0 - initial release
// ============================================================================
module lsq_unit #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   alloc_valid,
    input  logic                   alloc_is_store,
    input  logic [TAG_W-1:0]       alloc_tag,
    output logic                   alloc_ready,
    input  logic                   exec_valid,
    input  logic [TAG_W-1:0]       exec_tag,
    input  logic [ADDR_W-1:0]      exec_address,
    input  logic [DATA_W-1:0]      exec_data,
    input  logic                   commit_valid,
    output logic                   commit_ready,
    output logic                   ld_result_valid,
    output logic [TAG_W-1:0]       ld_result_tag,
    output logic [DATA_W-1:0]      ld_result_data,
    output logic                   mem_req_valid,
    output logic                   mem_req_write,
    output logic [ADDR_W-1:0]      mem_req_address,
    output logic [DATA_W-1:0]      mem_req_wdata,
    input  logic                   mem_busy,
    input  logic                   mem_resp_valid,
    input  logic [DATA_W-1:0]      mem_resp_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    localparam int C_PTR_W = $clog2(DEPTH);
    localparam int C_CNT_W = C_PTR_W + 1;
    localparam logic [C_CNT_W-1:0] C_FULL = C_CNT_W'(DEPTH);

    // Per-entry state; the control bits are reset, the payload is not.
    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_is_store;
    logic [DEPTH-1:0]  r_addr_ok;
    logic [DEPTH-1:0]  r_data_ok;
    logic [DEPTH-1:0]  r_issued;
    logic [DEPTH-1:0]  r_done;
    logic [TAG_W-1:0]  r_tag  [DEPTH];
    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];

    logic [C_PTR_W-1:0] r_head;
    logic [C_PTR_W-1:0] r_tail;
    logic [C_CNT_W-1:0] r_count;
    logic               r_rd_out;
    logic [C_PTR_W-1:0] r_rd_idx;
    logic               r_ld_valid;
    logic [TAG_W-1:0]   r_ld_tag;
    logic [DATA_W-1:0]  r_ld_data;

    logic [DEPTH-1:0]   w_exec_hit;
    logic               w_sel_found;
    logic [C_PTR_W-1:0] w_sel_idx;
    logic [C_CNT_W-1:0] w_sel_off;
    logic               w_older_unknown;
    logic               w_match;
    logic               w_match_ok;
    logic [DATA_W-1:0]  w_match_data;
    logic               w_resp_fire;
    logic               w_head_store_ok;
    logic               w_st_req;
    logic               w_ld_go;
    logic               w_fwd;
    logic               w_rd_req;
    logic               w_rd_accept;
    logic               w_commit;
    logic               w_alloc;

    // Physical slot that sits a given number of entries after the head.
    function automatic logic [C_PTR_W-1:0] f_slot(input logic [C_PTR_W-1:0] base, input int off);
        return base + C_PTR_W'(off);
    endfunction

    // Tag CAM: exec updates only a live entry carrying the same tag.
    for (genvar g = 0; g < DEPTH; g++) begin : g_cam
        assign w_exec_hit[g] = exec_valid && r_valid[g] && (r_tag[g] == exec_tag);
    end

    // Pick the oldest ready load, then scan the older stores for hazards and forwarding.
    always_comb begin
        w_sel_found     = 1'b0;
        w_sel_idx       = '0;
        w_sel_off       = '0;
        w_older_unknown = 1'b0;
        w_match         = 1'b0;
        w_match_ok      = 1'b0;
        w_match_data    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!w_sel_found && r_valid[f_slot(r_head, i)] && !r_is_store[f_slot(r_head, i)] &&
                r_addr_ok[f_slot(r_head, i)] && !r_done[f_slot(r_head, i)] &&
                !r_issued[f_slot(r_head, i)]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = f_slot(r_head, i);
                w_sel_off   = C_CNT_W'(i);
            end
        end
        // Walking oldest to youngest lets the last hit be the youngest older store.
        for (int i = 0; i < DEPTH; i++) begin
            if (w_sel_found && (C_CNT_W'(i) < w_sel_off) && r_valid[f_slot(r_head, i)] &&
                r_is_store[f_slot(r_head, i)]) begin
                if (!r_addr_ok[f_slot(r_head, i)]) begin
                    w_older_unknown = 1'b1;
                end else if (r_addr[f_slot(r_head, i)] == r_addr[w_sel_idx]) begin
                    w_match      = 1'b1;
                    w_match_ok   = r_data_ok[f_slot(r_head, i)];
                    w_match_data = r_data[f_slot(r_head, i)];
                end
            end
        end
    end

    // A returning read wins the result register; a same-cycle forward retries next cycle.
    assign w_resp_fire     = mem_resp_valid && r_rd_out;
    assign w_head_store_ok = r_valid[r_head] && r_is_store[r_head] &&
                             r_addr_ok[r_head] && r_data_ok[r_head];
    assign w_st_req        = commit_valid && w_head_store_ok;
    assign w_ld_go         = w_sel_found && !w_older_unknown;
    assign w_fwd           = w_ld_go && w_match && w_match_ok && !w_resp_fire;
    assign w_rd_req        = w_ld_go && !w_match && !r_rd_out && !w_st_req;
    assign w_rd_accept     = w_rd_req && !mem_busy;

    assign commit_ready = r_valid[r_head] &&
                          (r_is_store[r_head] ? (r_addr_ok[r_head] && r_data_ok[r_head] && !mem_busy)
                                              : r_done[r_head]);
    assign w_commit     = commit_valid && commit_ready;
    assign alloc_ready  = (r_count != C_FULL);
    assign w_alloc      = alloc_valid && alloc_ready;

    assign mem_req_valid   = w_st_req || w_rd_req;
    assign mem_req_write   = w_st_req;
    assign mem_req_address = w_st_req ? r_addr[r_head] : (w_rd_req ? r_addr[w_sel_idx] : '0);
    assign mem_req_wdata   = w_st_req ? r_data[r_head] : '0;

    assign ld_result_valid = r_ld_valid;
    assign ld_result_tag   = r_ld_tag;
    assign ld_result_data  = r_ld_data;
    assign count           = r_count;
    assign empty           = (r_count == '0);

    // Queue pointers, occupancy, the outstanding-read tracker and the result register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_rd_out   <= 1'b0;
            r_rd_idx   <= '0;
            r_ld_valid <= 1'b0;
            r_ld_tag   <= '0;
            r_ld_data  <= '0;
        end else begin
            if (w_alloc) begin
                r_tail <= r_tail + C_PTR_W'(1);
            end
            if (w_commit) begin
                r_head <= r_head + C_PTR_W'(1);
            end
            case ({w_alloc, w_commit})
                2'b10:   r_count <= r_count + C_CNT_W'(1);
                2'b01:   r_count <= r_count - C_CNT_W'(1);
                default: r_count <= r_count;
            endcase

            r_ld_valid <= 1'b0;
            if (w_resp_fire) begin
                r_ld_valid <= 1'b1;
                r_ld_tag   <= r_tag[r_rd_idx];
                r_ld_data  <= mem_resp_data;
                r_rd_out   <= 1'b0;
            end else if (w_fwd) begin
                r_ld_valid <= 1'b1;
                r_ld_tag   <= r_tag[w_sel_idx];
                r_ld_data  <= w_match_data;
            end

            if (w_rd_accept) begin
                r_rd_out <= 1'b1;
                r_rd_idx <= w_sel_idx;
            end
        end
    end

    // Entry status bits: allocate, exec update, issue, completion and retire.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid    <= '0;
            r_is_store <= '0;
            r_addr_ok  <= '0;
            r_data_ok  <= '0;
            r_issued   <= '0;
            r_done     <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_commit && (C_PTR_W'(i) == r_head)) begin
                    r_valid[i] <= 1'b0;
                end
                if (w_alloc && (C_PTR_W'(i) == r_tail)) begin
                    r_valid[i]    <= 1'b1;
                    r_is_store[i] <= alloc_is_store;
                    r_addr_ok[i]  <= 1'b0;
                    r_data_ok[i]  <= 1'b0;
                    r_issued[i]   <= 1'b0;
                    r_done[i]     <= 1'b0;
                end
                if (w_exec_hit[i]) begin
                    r_addr_ok[i] <= 1'b1;
                    if (r_is_store[i]) begin
                        r_data_ok[i] <= 1'b1;
                    end
                end
                if (w_rd_accept && (C_PTR_W'(i) == w_sel_idx)) begin
                    r_issued[i] <= 1'b1;
                end
                if ((w_resp_fire && (C_PTR_W'(i) == r_rd_idx)) ||
                    (w_fwd && (C_PTR_W'(i) == w_sel_idx))) begin
                    r_done[i] <= 1'b1;
                end
            end
        end
    end

    // Entry payload: tag at allocation, address and store data at exec.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_alloc && (C_PTR_W'(i) == r_tail)) begin
                r_tag[i] <= alloc_tag;
            end
            if (w_exec_hit[i]) begin
                r_addr[i] <= exec_address;
                if (r_is_store[i]) begin
                    r_data[i] <= exec_data;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsq_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsq_unit
// Brief    : Self-checking bench for lsq_unit: directed vector table, fill and
//            reset sequence, and a randomized program checked against
//            program-order memory semantics.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsq_unit;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 6;
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int N_OPS  = 300;
    localparam int N_VEC  = 27;

    logic              clk = 1'b0;
    logic              reset;
    logic              alloc_valid, alloc_is_store, alloc_ready;
    logic [TAG_W-1:0]  alloc_tag;
    logic              exec_valid;
    logic [TAG_W-1:0]  exec_tag;
    logic [ADDR_W-1:0] exec_address;
    logic [DATA_W-1:0] exec_data;
    logic              commit_valid, commit_ready;
    logic              ld_result_valid;
    logic [TAG_W-1:0]  ld_result_tag;
    logic [DATA_W-1:0] ld_result_data;
    logic              mem_req_valid, mem_req_write;
    logic [ADDR_W-1:0] mem_req_address;
    logic [DATA_W-1:0] mem_req_wdata;
    logic              mem_busy, mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;
    logic [CNT_W-1:0]  count;
    logic              empty;

    lsq_unit #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_is_store(alloc_is_store), .alloc_tag(alloc_tag),
        .alloc_ready(alloc_ready),
        .exec_valid(exec_valid), .exec_tag(exec_tag), .exec_address(exec_address),
        .exec_data(exec_data),
        .commit_valid(commit_valid), .commit_ready(commit_ready),
        .ld_result_valid(ld_result_valid), .ld_result_tag(ld_result_tag),
        .ld_result_data(ld_result_data),
        .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write),
        .mem_req_address(mem_req_address), .mem_req_wdata(mem_req_wdata),
        .mem_busy(mem_busy), .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid    = 1'b0;
        alloc_is_store = 1'b0;
        alloc_tag      = '0;
        exec_valid     = 1'b0;
        exec_tag       = '0;
        exec_address   = '0;
        exec_data      = '0;
        commit_valid   = 1'b0;
        mem_busy       = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
    endtask

    // One cycle of stimulus plus the combinational (before edge) and registered (after edge) expectations.
    typedef struct {
        logic        av, ast;
        logic [31:0] atag;
        logic        ev;
        logic [31:0] etag, eaddr, edata;
        logic        cv, busy, rv;
        logic [31:0] rdata;
        logic        crdy, mrv, mrw;
        logic [31:0] maddr, mwd;
        logic        lv;
        logic [31:0] ltag, ldata, cnt;
    } vec_t;

    vec_t vt[N_VEC];

    function automatic vec_t v(input bit av, input bit ast, input int atag,
                               input bit ev, input int etag, input int eaddr, input int edata,
                               input bit cv, input bit busy, input bit rv, input int rdata,
                               input bit crdy, input bit mrv, input bit mrw, input int maddr,
                               input int mwd, input bit lv, input int ltag, input int ldata,
                               input int cnt);
        vec_t r;
        r.av = av; r.ast = ast; r.atag = atag;
        r.ev = ev; r.etag = etag; r.eaddr = eaddr; r.edata = edata;
        r.cv = cv; r.busy = busy; r.rv = rv; r.rdata = rdata;
        r.crdy = crdy; r.mrv = mrv; r.mrw = mrw; r.maddr = maddr; r.mwd = mwd;
        r.lv = lv; r.ltag = ltag; r.ldata = ldata; r.cnt = cnt;
        return r;
    endfunction

    // Randomized program and its program-order expectations.
    typedef struct {
        bit          st;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } op_t;

    op_t         prog[N_OPS];
    logic [31:0] gmem[16];
    logic [31:0] cmem[16];
    bit          execd[N_OPS];
    bit          resp_seen[N_OPS];

    initial begin
        int n_alloc, n_commit, cyc, ex_idx, found, rd_wait;
        bit rd_pend, do_alloc, do_commit;
        logic [31:0] rd_q;
        int cand[$];

        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset alloc_ready", 64'(alloc_ready), 64'(1));
        check("reset empty", 64'(empty), 64'(1));
        check("reset count", 64'(count), 64'(0));
        check("reset commit_ready", 64'(commit_ready), 64'(0));
        check("reset mem_req_valid", 64'(mem_req_valid), 64'(0));
        check("reset ld_result_valid", 64'(ld_result_valid), 64'(0));
        reset = 1'b0;

        //          av ast atag  ev etag eaddr edata   cv bsy rv rdata    crdy mrv mrw maddr mwd     lv ltag ldata  cnt
        vt[0]  = v(1, 1, 3,   0, 0,  0,    0,      0, 0, 0, 0,       0, 0, 0, 0,    0,      0, 0,  0,      1);
        vt[1]  = v(1, 0, 4,   1, 3,  'h40, 'hDEAD, 0, 0, 0, 0,       0, 0, 0, 0,    0,      0, 0,  0,      2);
        vt[2]  = v(0, 0, 0,   1, 4,  'h40, 0,      0, 0, 0, 0,       1, 0, 0, 0,    0,      0, 0,  0,      2);
        vt[3]  = v(0, 0, 0,   0, 0,  0,    0,      0, 0, 0, 0,       1, 0, 0, 0,    0,      1, 4,  'hDEAD, 2);
        vt[4]  = v(0, 0, 0,   0, 0,  0,    0,      0, 0, 0, 0,       1, 0, 0, 0,    0,      0, 0,  0,      2);
        vt[5]  = v(0, 0, 0,   0, 0,  0,    0,      1, 1, 0, 0,       0, 1, 1, 'h40, 'hDEAD, 0, 0,  0,      2);
        vt[6]  = v(0, 0, 0,   0, 0,  0,    0,      1, 1, 0, 0,       0, 1, 1, 'h40, 'hDEAD, 0, 0,  0,      2);
        vt[7]  = v(0, 0, 0,   0, 0,  0,    0,      1, 1, 0, 0,       0, 1, 1, 'h40, 'hDEAD, 0, 0,  0,      2);
        vt[8]  = v(0, 0, 0,   0, 0,  0,    0,      1, 0, 0, 0,       1, 1, 1, 'h40, 'hDEAD, 0, 0,  0,      1);
        vt[9]  = v(0, 0, 0,   0, 0,  0,    0,      1, 0, 0, 0,       1, 0, 0, 0,    0,      0, 0,  0,      0);
        vt[10] = v(1, 1, 6,   0, 0,  0,    0,      0, 0, 0, 0,       0, 0, 0, 0,    0,      0, 0,  0,      1);
        vt[11] = v(1, 0, 5,   0, 0,  0,    0,      0, 0, 0, 0,       0, 0, 0, 0,    0,      0, 0,  0,      2);
        vt[12] = v(0, 0, 0,   1, 5,  'h80, 0,      0, 0, 0, 0,       0, 0, 0, 0,    0,      0, 0,  0,      2);
        vt[13] = v(0, 0, 0,   0, 0,  0,    0,      0, 0, 0, 0,       0, 0, 0, 0,    0,      0, 0,  0,      2);
        vt[14] = v(0, 0, 0,   1, 6,  'h90, 'h77,   0, 0, 0, 0,       0, 0, 0, 0,    0,      0, 0,  0,      2);
        vt[15] = v(0, 0, 0,   0, 0,  0,    0,      0, 0, 0, 0,       1, 1, 0, 'h80, 0,      0, 0,  0,      2);
        vt[16] = v(0, 0, 0,   0, 0,  0,    0,      0, 0, 1, 'h1234,  1, 0, 0, 0,    0,      1, 5,  'h1234, 2);
        vt[17] = v(0, 0, 0,   0, 0,  0,    0,      1, 0, 0, 0,       1, 1, 1, 'h90, 'h77,   0, 0,  0,      1);
        vt[18] = v(0, 0, 0,   0, 0,  0,    0,      1, 0, 0, 0,       1, 0, 0, 0,    0,      0, 0,  0,      0);
        vt[19] = v(1, 1, 10,  0, 0,  0,    0,      0, 0, 0, 0,       0, 0, 0, 0,    0,      0, 0,  0,      1);
        vt[20] = v(1, 1, 11,  1, 10, 'h40, 1,      0, 0, 0, 0,       0, 0, 0, 0,    0,      0, 0,  0,      2);
        vt[21] = v(1, 0, 12,  1, 11, 'h40, 2,      0, 0, 0, 0,       1, 0, 0, 0,    0,      0, 0,  0,      3);
        vt[22] = v(0, 0, 0,   1, 12, 'h40, 0,      0, 0, 0, 0,       1, 0, 0, 0,    0,      0, 0,  0,      3);
        vt[23] = v(0, 0, 0,   0, 0,  0,    0,      0, 0, 0, 0,       1, 0, 0, 0,    0,      1, 12, 2,      3);
        vt[24] = v(0, 0, 0,   0, 0,  0,    0,      1, 0, 0, 0,       1, 1, 1, 'h40, 1,      0, 0,  0,      2);
        vt[25] = v(0, 0, 0,   0, 0,  0,    0,      1, 0, 0, 0,       1, 1, 1, 'h40, 2,      0, 0,  0,      1);
        vt[26] = v(0, 0, 0,   0, 0,  0,    0,      1, 0, 0, 0,       1, 0, 0, 0,    0,      0, 0,  0,      0);

        // Forwarding, disambiguation, busy-stalled store commit, youngest-store forwarding.
        for (int k = 0; k < N_VEC; k++) begin
            alloc_valid    = vt[k].av;
            alloc_is_store = vt[k].ast;
            alloc_tag      = vt[k].atag[TAG_W-1:0];
            exec_valid     = vt[k].ev;
            exec_tag       = vt[k].etag[TAG_W-1:0];
            exec_address   = vt[k].eaddr;
            exec_data      = vt[k].edata;
            commit_valid   = vt[k].cv;
            mem_busy       = vt[k].busy;
            mem_resp_valid = vt[k].rv;
            mem_resp_data  = vt[k].rdata;
            #1;
            check($sformatf("v%0d commit_ready", k), 64'(commit_ready), 64'(vt[k].crdy));
            check($sformatf("v%0d mem_req_valid", k), 64'(mem_req_valid), 64'(vt[k].mrv));
            check($sformatf("v%0d mem_req_write", k), 64'(mem_req_write), 64'(vt[k].mrw));
            check($sformatf("v%0d mem_req_address", k), 64'(mem_req_address), 64'(vt[k].maddr));
            check($sformatf("v%0d mem_req_wdata", k), 64'(mem_req_wdata), 64'(vt[k].mwd));
            step();
            check($sformatf("v%0d ld_result_valid", k), 64'(ld_result_valid), 64'(vt[k].lv));
            if (vt[k].lv) begin
                check($sformatf("v%0d ld_result_tag", k), 64'(ld_result_tag), 64'(vt[k].ltag));
                check($sformatf("v%0d ld_result_data", k), 64'(ld_result_data), 64'(vt[k].ldata));
            end
            check($sformatf("v%0d count", k), 64'(count), 64'(vt[k].cnt));
        end
        idle();

        // Fill to capacity with loads 1..8, overflow attempt, then complete and retire one.
        for (int k = 1; k <= DEPTH; k++) begin
            alloc_valid = 1'b1;
            alloc_tag   = TAG_W'(k);
            step();
        end
        idle();
        check("full count", 64'(count), 64'(DEPTH));
        check("full alloc_ready", 64'(alloc_ready), 64'(0));
        alloc_valid = 1'b1;
        alloc_tag   = TAG_W'(9);
        step();
        idle();
        check("overflow count", 64'(count), 64'(DEPTH));
        exec_valid   = 1'b1;
        exec_tag     = TAG_W'(1);
        exec_address = 32'h100;
        step();
        idle();
        #1;
        check("fill rd valid", 64'(mem_req_valid), 64'(1));
        check("fill rd addr", 64'(mem_req_address), 64'(32'h100));
        step();
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h55;
        step();
        idle();
        check("fill ld valid", 64'(ld_result_valid), 64'(1));
        check("fill ld tag", 64'(ld_result_tag), 64'(1));
        check("fill ld data", 64'(ld_result_data), 64'(32'h55));
        commit_valid = 1'b1;
        #1;
        check("fill commit_ready", 64'(commit_ready), 64'(1));
        step();
        idle();
        check("fill count after commit", 64'(count), 64'(DEPTH - 1));
        check("fill alloc_ready after commit", 64'(alloc_ready), 64'(1));

        // Reset while a read is outstanding; the stale response must be dropped.
        exec_valid   = 1'b1;
        exec_tag     = TAG_W'(2);
        exec_address = 32'h104;
        step();
        idle();
        #1;
        check("pre-reset rd valid", 64'(mem_req_valid), 64'(1));
        step();
        #2;
        reset = 1'b1;
        #1;
        check("async reset empty", 64'(empty), 64'(1));
        check("async reset count", 64'(count), 64'(0));
        check("async reset alloc_ready", 64'(alloc_ready), 64'(1));
        check("async reset mem_req_valid", 64'(mem_req_valid), 64'(0));
        step();
        reset = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h99;
        step();
        idle();
        check("stale resp dropped", 64'(ld_result_valid), 64'(0));
        check("stale resp count", 64'(count), 64'(0));

        // Random program: loads must return the program-order value, stores must hit the cache in order.
        for (int k = 0; k < 16; k++) begin
            gmem[k] = 32'hA000 + k;
            cmem[k] = 32'hA000 + k;
        end
        for (int i = 0; i < N_OPS; i++) begin
            prog[i].st   = ($urandom_range(0, 1) == 1);
            prog[i].addr = 32'(4 * $urandom_range(0, 7));
            prog[i].data = $urandom;
            prog[i].exp  = '0;
            if (prog[i].st) gmem[prog[i].addr[5:2]] = prog[i].data;
            else            prog[i].exp = gmem[prog[i].addr[5:2]];
            execd[i]     = 1'b0;
            resp_seen[i] = 1'b0;
        end
        n_alloc  = 0;
        n_commit = 0;
        cyc      = 0;
        rd_pend  = 1'b0;
        rd_wait  = 0;
        rd_q     = '0;
        while (n_commit < N_OPS && cyc < 20000) begin
            idle();
            if (n_alloc < N_OPS && $urandom_range(0, 3) != 0) begin
                alloc_valid    = 1'b1;
                alloc_is_store = prog[n_alloc].st;
                alloc_tag      = TAG_W'(n_alloc);
            end
            cand.delete();
            for (int i = n_commit; i < n_alloc; i++) if (!execd[i]) cand.push_back(i);
            ex_idx = -1;
            if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
                ex_idx       = cand[$urandom_range(0, cand.size() - 1)];
                exec_valid   = 1'b1;
                exec_tag     = TAG_W'(ex_idx);
                exec_address = prog[ex_idx].addr;
                exec_data    = prog[ex_idx].data;
            end
            commit_valid = ($urandom_range(0, 3) != 0);
            mem_busy     = ($urandom_range(0, 3) == 0);
            if (rd_pend && rd_wait == 0) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = rd_q;
            end
            #1;
            do_alloc  = alloc_valid && alloc_ready;
            do_commit = commit_valid && commit_ready;
            if (do_commit) begin
                if (prog[n_commit].st) begin
                    check("rnd st req", 64'({mem_req_valid, mem_req_write}), 64'(2'b11));
                    check("rnd st addr", 64'(mem_req_address), 64'(prog[n_commit].addr));
                    check("rnd st data", 64'(mem_req_wdata), 64'(prog[n_commit].data));
                    cmem[prog[n_commit].addr[5:2]] = prog[n_commit].data;
                end else begin
                    check("rnd ld done before commit", 64'(resp_seen[n_commit]), 64'(1));
                end
            end
            if (mem_resp_valid) rd_pend = 1'b0;
            else if (rd_pend) rd_wait--;
            if (mem_req_valid && !mem_req_write && !mem_busy) begin
                check("rnd single read", 64'(rd_pend), 64'(0));
                rd_pend = 1'b1;
                rd_wait = $urandom_range(0, 3);
                rd_q    = cmem[mem_req_address[5:2]];
            end
            step();
            if (ld_result_valid) begin
                found = -1;
                for (int i = n_commit; i < n_alloc; i++) begin
                    if (!prog[i].st && execd[i] && !resp_seen[i] && TAG_W'(i) == ld_result_tag) found = i;
                end
                check("rnd ld tag known", 64'(found >= 0), 64'(1));
                if (found >= 0) begin
                    check($sformatf("rnd ld data op%0d", found), 64'(ld_result_data), 64'(prog[found].exp));
                    resp_seen[found] = 1'b1;
                end
            end
            if (do_alloc) n_alloc++;
            if (do_commit) n_commit++;
            if (ex_idx >= 0) execd[ex_idx] = 1'b1;
            check("rnd count", 64'(count), 64'(n_alloc - n_commit));
            cyc++;
        end
        idle();
        check("rnd all committed", 64'(n_commit), 64'(N_OPS));
        step();
        check("rnd final empty", 64'(empty), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsq_unit.md
Name: lsq_unit

Overview:
- Parametrised load/store queue plus memory-access stage; successor to the combinational memory stage.
- Holds in-flight memory ops in program order (circular buffer, head/tail), tracks address/data readiness, forwards store data to younger loads, issues loads to the data cache and writes stores at commit.
- Sits between execute (address/data producer) and the data cache; results go to writeback.

Parameters:
DEPTH, 8, queue entries (power of 2, >=2)
ADDR_W, 32, address width
DATA_W, 32, data word width
TAG_W, 6, instruction tag width

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
alloc_valid  in  1  dispatch allocates an entry at tail this cycle
alloc_is_store  in  1  1=store, 0=load
alloc_tag  in  TAG_W  tag of allocated op
alloc_ready  out  1  queue not full
exec_valid  in  1  execute delivers address (and store data)
exec_tag  in  TAG_W  tag to update (CAM match)
exec_address  in  ADDR_W  effective address
exec_data  in  DATA_W  store data (ignored for loads)
commit_valid  in  1  retire request for head entry
commit_ready  out  1  head can retire this cycle
ld_result_valid  out  1  load result valid (registered)
ld_result_tag  out  TAG_W  tag of completing load
ld_result_data  out  DATA_W  load value
mem_req_valid  out  1  cache request
mem_req_write  out  1  1=store write, 0=load read
mem_req_address  out  ADDR_W  request address
mem_req_wdata  out  DATA_W  write data
mem_busy  in  1  cache cannot accept request this cycle
mem_resp_valid  in  1  read data returned
mem_resp_data  in  DATA_W  read data
count  out  $clog2(DEPTH)+1  occupied entries
empty  out  1  count==0

Behaviour:
- Reset (async): head=tail=count=0, all entry valid bits 0, read-outstanding 0; outputs 0 except alloc_ready=1, empty=1.
- Entry fields: valid, is_store, tag, addr, addr_ok, data, data_ok, issued, done.
- Alloc: if alloc_valid && alloc_ready, write entry at tail with addr_ok=data_ok=issued=done=0; tail wraps DEPTH-1 -> 0. alloc_valid when full is ignored (no state change).
- Exec: if exec_valid, the valid entry whose tag matches gets addr, addr_ok=1; a store also gets data, data_ok=1. No match: ignored. Tags are unique among valid entries.
- Load selection (each cycle): oldest valid load (from head) with addr_ok && !done && !issued. Scan older entries, youngest first:
  - older store with addr_ok=0: load waits (conservative disambiguation);
  - youngest older store with equal addr and data_ok: forward; next cycle ld_result_valid=1 with that data; entry done=1. No cache access;
  - matching store with data_ok=0: wait;
  - no match: issue read when no read outstanding and port free; issued=1.
- One outstanding read. mem_resp_valid -> next cycle ld_result_valid=1 with the issued load's tag/data; done=1, outstanding=0.
- ld_result: 1-cycle pulse, registered. Forward and response in the same cycle: response reported first, forward retried next cycle.
- Port arbitration: a committing store's write has priority over a load read. Request accepted iff mem_req_valid && !mem_busy; outputs held stable while busy.
- commit_ready: head valid and (load: done; store: addr_ok && data_ok && !mem_busy). Store commit drives mem_req_valid=1, mem_req_write=1 the same cycle (combinational from head). Commit frees head; head wraps.
- Alloc and commit in the same cycle: count unchanged; legal when full (the freed slot is not reusable the same cycle; alloc_ready is from registered count).
- Full: count==DEPTH -> alloc_ready=0. Empty: commit_valid ignored, commit_ready=0.
- Reset mid-operation clears all entries and the outstanding read; a later mem_resp_valid with no outstanding read is dropped.

Test Plan:
- Reset, then alloc 8 loads tags 1..8 (DEPTH=8) -> count=8, alloc_ready=0; 9th alloc ignored; commit 1 after completion -> count=7, alloc_ready=1.
- Store tag 3 addr 0x40 data 0xDEAD, then load tag 4 addr 0x40 -> ld_result tag 4 data 0xDEAD one cycle after load exec; no mem_req_valid.
- Load tag 5 addr 0x80 with older store addr unknown -> no issue; store exec addr 0x90 -> read 0x80 issued; resp 0x1234 -> ld_result tag 5 data 0x1234 next cycle.
- Two older stores to 0x40 (data 0x1, then 0x2) before a load to 0x40 -> forwards 0x2.
- Store at head, commit with mem_busy=1 for 3 cycles -> commit_ready=0, request held stable; busy drops -> write 0x40/0xDEAD accepted, head advances.
- Wrap: 20 alloc/commit pairs at DEPTH=4 -> head/tail wrap, tags and results correct; assert reset with a read outstanding -> empty=1, later resp ignored.
